// File: rtl/fxp_div_pkg.sv
// Shared types and helpers for the sequential fixed-point divider.
package fxp_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach W+F-1; it never wraps past W+F.
  function automatic int cnt_width(input int w, input int f);
    return $clog2(w + f + 1);
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One restoring division step: shift the next dividend bit into the
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module fxp_div_step #(
  parameter int W = 10
) (
  input  logic [W:0]   i_acc,
  input  logic         i_d_msb,
  input  logic [W-1:0] i_b,
  output logic [W:0]   o_acc,
  output logic         o_qbit
);

  localparam int AW = W + 1;

  // One spare bit above the remainder so the shift can never lose the MSB.
  logic [W+1:0] w_shift;

  always_comb begin
    w_shift = {i_acc, i_d_msb};
    o_qbit  = (w_shift >= {2'b00, i_b});
    o_acc   = o_qbit ? AW'(w_shift - {2'b00, i_b}) : w_shift[W:0];
  end

endmodule

// File: rtl/fxp_divider_seq.sv
// Sequential unsigned Q(W-F).F divider, one quotient bit per cycle.
// Define FXP_DIV_SAT_EN to saturate q to all ones on overflow.
module fxp_divider_seq
  import fxp_div_pkg::*;
#(
  parameter int W = 10,
  parameter int F = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] q,
  output logic         ov,
  output logic         dvz
);

  localparam int DW = W + F;
  localparam int CW = cnt_width(W, F);

  state_t        r_state;
  state_t        w_state_next;
  logic [W:0]    r_acc;
  logic [DW-1:0] r_d;
  logic [DW-1:0] r_qint;
  logic [W-1:0]  r_b;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_q;
  logic          r_ov;
  logic          r_dvz;

  logic [W:0]    w_acc_next;
  logic          w_qbit;
  logic          w_accept;
  logic          w_last;
  logic [DW-1:0] w_qint_next;
  logic          w_ov_next;
  logic [W-1:0]  w_q_next;

  assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last      = (r_state == RUN) && (r_cnt == CW'(DW - 1));
  assign w_qint_next = {r_qint[DW-2:0], w_qbit};

  fxp_div_step #(.W(W)) u_step (
    .i_acc   (r_acc),
    .i_d_msb (r_d[DW-1]),
    .i_b     (r_b),
    .o_acc   (w_acc_next),
    .o_qbit  (w_qbit)
  );

  // Any quotient bit above the low W bits means the result does not fit.
  generate
    if (F > 0) begin : g_ov
      assign w_ov_next = |w_qint_next[DW-1:W];
    end else begin : g_no_ov
      assign w_ov_next = 1'b0;
    end
  endgenerate

`ifdef FXP_DIV_SAT_EN
  assign w_q_next = w_ov_next ? '1 : w_qint_next[W-1:0];
`else
  assign w_q_next = w_qint_next[W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (start) w_state_next = (b != '0) ? RUN : DONE;
      RUN:  if (w_last) w_state_next = DONE;
      DONE: begin
        if (start) w_state_next = (b != '0) ? RUN : DONE;
        else       w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_d    <= '0;
      r_qint <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_ov   <= 1'b0;
      r_dvz  <= 1'b0;
    end else if (w_accept) begin
      if (b != '0) begin
        r_b    <= b;
        r_d    <= DW'(a) << F;
        r_acc  <= '0;
        r_qint <= '0;
        r_cnt  <= '0;
        r_q    <= '0;
        r_ov   <= 1'b0;
        r_dvz  <= 1'b0;
      end else begin
        // Divide by zero skips RUN and reports immediately.
        r_q    <= '1;
        r_ov   <= 1'b0;
        r_dvz  <= 1'b1;
      end
    end else if (r_state == RUN) begin
      r_acc  <= w_acc_next;
      r_d    <= {r_d[DW-2:0], 1'b0};
      r_qint <= w_qint_next;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        r_q  <= w_q_next;
        r_ov <= w_ov_next;
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign q    = r_q;
  assign ov   = r_ov;
  assign dvz  = r_dvz;

endmodule

// File: tb/tb_fxp_divider_seq.sv
// Randomised and directed check of fxp_divider_seq against an arithmetic model.
module tb_fxp_divider_seq;

  localparam int W = 10;
  localparam int F = 5;
  localparam int LAT = W + F + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         ov;
  logic         dvz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fxp_divider_seq #(.W(W), .F(F)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .ov    (ov),
    .dvz   (dvz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Quotient = floor(a * 2^F / b) in plain integer arithmetic.
  function automatic void model(input int ua, input int ub,
                                output int eq, output bit eov, output bit edvz);
    longint qi;
    if (ub == 0) begin
      eq = (1 << W) - 1; eov = 1'b0; edvz = 1'b1;
    end else begin
      qi   = (longint'(ua) << F) / longint'(ub);
      eov  = (qi >= (longint'(1) << W));
      eq   = int'(qi % (longint'(1) << W));
`ifdef FXP_DIV_SAT_EN
      if (eov) eq = (1 << W) - 1;
`endif
      edvz = 1'b0;
    end
  endfunction

  // Count negedges after the accept edge until done; busy counted on the way.
  task automatic wait_done(input int glitch, output int cyc, output int nbusy);
    cyc = 1; nbusy = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      start = (cyc == glitch);
      if (cyc == glitch) begin a = W'($urandom); b = W'($urandom); end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic do_div(input int ua, input int ub, input int glitch);
    int eq, cyc, nbusy;
    bit eov, edvz;
    model(ua, ub, eq, eov, edvz);
    @(negedge clk);
    a = W'(ua); b = W'(ub); start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    wait_done(glitch, cyc, nbusy);
    $display("[TB] a=%0d b=%0d -> q=%0d ov=%0d dvz=%0d lat=%0d (exp q=%0d ov=%0d dvz=%0d)",
             ua, ub, q, ov, dvz, cyc, eq, eov, edvz);
    check("latency", cyc, (ub == 0) ? 1 : LAT);
    check("busy_cycles", nbusy, (ub == 0) ? 0 : W + F);
    check("done", done, 1);
    check("q", q, eq);
    check("ov", ov, eov);
    check("dvz", dvz, edvz);
    @(negedge clk);
    check("done_width", done, 0);
    check("q_hold", q, eq);
  endtask

  initial begin
    int eq1, eq2, cyc, nbusy;
    bit eov1, eov2, edvz1, edvz2;
    int ra, rb;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_ov", ov, 0);
    check("rst_dvz", dvz, 0);
    rst = 1'b0;

    do_div(96, 64, 0);
    do_div(32, 96, 0);
    do_div(992, 16, 0);
    do_div(100, 0, 0);

    // Reset during RUN discards the division.
    @(negedge clk);
    a = 10'd500; b = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_q", q, 0);
    check("midrst_done", done, 0);
    cyc = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    check("midrst_discard", cyc, 0);
    $display("[TB] reset during RUN: busy=%0d q=%0d", busy, q);

    do_div(64, 32, 5);

    // Back-to-back: start held through DONE.
    model(96, 64, eq1, eov1, edvz1);
    model(32, 96, eq2, eov2, edvz2);
    @(negedge clk);
    a = 10'd96; b = 10'd64; start = 1'b1;
    @(negedge clk);
    a = 10'd32; b = 10'd96;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_lat1", cyc, LAT);
    check("b2b_q1", q, eq1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_done_width", done, 0);
    check("b2b_busy2", busy, 1);
    check("b2b_q_cleared", q, 0);
    wait_done(0, cyc, nbusy);
    check("b2b_lat2", cyc, LAT);
    check("b2b_q2", q, eq2);
    check("b2b_ov2", ov, eov2);
    $display("[TB] back-to-back: q1=%0d q2=%0d", eq1, q);

    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom_range(0, (1 << W) - 1));
      rb = (i % 5 == 0) ? 0 : int'($urandom_range(1, (1 << W) - 1));
      do_div(ra, rb, int'($urandom_range(0, W + F - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_divider_seq.md
Name: fxp_divider_seq

Overview:
- Parametrised sequential unsigned fixed-point divider computing Q = A / B.
- Operands and result are W bits wide with F fraction bits, i.e. Q(W-F).F format.
- Uses a restoring shift/subtract algorithm that produces one quotient bit per cycle, with a start/busy/done handshake.
- Next generation of the fixed 10-bit divider datapath:
  - generalised width and fraction;
  - integrated control FSM;
  - explicit result-valid timing;
  - divide-by-zero and overflow flags that are registered and stable.

Parameters:
- W, 10: operand/result width in bits (must be ≥ 2).
- F, 5: fraction bits in A, B and Q (must be in 0..W-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a division; sampled only in IDLE or DONE.
- a  in  W  dividend, Q(W-F).F unsigned; captured on accepted start.
- b  in  W  divisor, Q(W-F).F unsigned; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when q/ov/dvz become valid.
- q  out  W  quotient, Q(W-F).F; held until the next accepted start.
- ov  out  1  quotient exceeds the W-bit range; valid with done, then held.
- dvz  out  1  b was zero; valid with done, then held.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-RUN):
  - state goes to IDLE;
  - q=0, ov=0, dvz=0, busy=0, done=0;
  - internal acc, dividend and counter cleared;
  - any in-flight division is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with b≠0: capture a and b; dividend register D (W+F bits) = a<<F; acc (W+1 bits) = 0; Qint (W+F bits) = 0; cnt = 0; go to RUN.
  - start=1 with b=0: go to DONE; dvz=1, ov=0, q = all ones.
- RUN, one iteration per cycle:
  - {acc, D} shifted left 1;
  - if the shifted acc ≥ b: acc -= b and the new Qint LSB = 1, else 0;
  - cnt increments;
  - after iteration W+F (cnt = W+F-1 at that edge), go to DONE.
- DONE, one cycle:
  - done=1;
  - q, ov, dvz registered on entry and held until the next accepted start;
  - start=1 in DONE is accepted exactly as in IDLE, allowing back-to-back operations; otherwise go to IDLE.
- ov = |Qint[W+F-1:W] (true quotient ≥ 2^(W-F)).
- q when ov=0: Qint[W-1:0]. q when ov=1: see Optional Feature.
- Fraction bits beyond F are truncated toward zero; no rounding.
- Latency:
  - start accepted at edge N → done high in the cycle after edge N+W+F (16 cycles for the defaults);
  - divide-by-zero case: done in the cycle after edge N.
- busy=1 only in RUN; start during RUN is ignored, and a/b changes are ignored.
- Counter width is $clog2(W+F+1); no wrap beyond W+F.
- q/ov/dvz change only on an accepted start (cleared to 0 on entry to RUN) or on entry to DONE.

Optional Feature:
- Macro FXP_DIV_SAT_EN.
- Defined: on ov=1, q saturates to all ones (max representable value).
- Undefined: on ov=1, q = Qint[W-1:0] (wrapped low bits); the ov flag is identical in both builds.

Decomposition:
- Shared package fxp_div_pkg:
  - state enum {IDLE, RUN, DONE};
  - function cnt_width(W, F) returning $clog2(W+F+1).
- One natural combinational sub-module, fxp_div_step:
  - inputs: acc, D MSB, b;
  - outputs: next acc, next quotient bit (restoring compare/subtract);
  - instanced once and reused each cycle.

Test Plan:
- W=10, F=5: a=96 (3.0), b=64 (2.0), start → done 16 cycles later, q=48 (1.5), ov=0, dvz=0, busy high for 15 cycles.
- a=32 (1.0), b=96 (3.0) → q=10 (0.3125, truncated), ov=0.
- a=992 (31.0), b=16 (0.5) → ov=1. With FXP_DIV_SAT_EN, q=1023; without it, q=960.
- b=0, a=100 → done on the next cycle, dvz=1, ov=0, q=1023; busy never asserts.
- rst=1 at RUN cycle 7 → next cycle IDLE, busy=0, q=0. A new division a=64, b=32 then returns q=64 (2.0) with normal latency. start pulsed during RUN is ignored, with no restart and unchanged latency.
- Back-to-back: start held high through DONE → second operation accepted in the DONE cycle. Each done is one cycle wide; q holds the first result until the second operation starts.
